// File: rtl/dbn_layer_engine.sv
// Streaming DBN layer engine: accumulates per-neuron popcount(in_data & w_n)
// over a run-time number of chunks, then applies a threshold activation.
// The popcount is registered ahead of the saturating add, so the final
// accumulate lands one cycle after the last chunk handshake.
module dbn_layer_engine #(
   parameter int unsigned CHUNK_W    = 256,
   parameter int unsigned N_PAR      = 16,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned MAX_CHUNKS = 64,
   parameter int unsigned CNT_W      = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_chunks,
   input  logic [ACC_W-1:0]         threshold,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CHUNK_W-1:0]       in_data,
   input  logic [N_PAR*CHUNK_W-1:0] in_weight,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_PAR*ACC_W-1:0]   out_sum,
   output logic [N_PAR-1:0]         out_bits,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
   output logic                     overflow
);

   localparam int unsigned PC_W  = $clog2(CHUNK_W + 1);
   localparam int unsigned SUM_W = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCUM    = 2'd1,
      ST_ACTIVATE = 2'd2,
      ST_OUTPUT   = 2'd3
   } state_t;

   // Number of set bits in one chunk-wide vector.
   function automatic logic [PC_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < CHUNK_W; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               cfg_err_q, cfg_err_d;

   logic               pass_start;
   logic               out_load;
   logic               accept;
   logic               last_accept;
   logic               cfg_ok;

   logic [CNT_W-1:0]   num_q;
   logic [ACC_W-1:0]   thr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               pc_vld_q;
   logic               overflow_q;

   logic [PC_W-1:0]    pc_q    [N_PAR];
   logic [ACC_W-1:0]   acc_q   [N_PAR];
   logic [ACC_W-1:0]   acc_nxt [N_PAR];
   logic [SUM_W-1:0]   sum_w   [N_PAR];
   logic               sat_any;

   logic [N_PAR*ACC_W-1:0] out_sum_q;
   logic [N_PAR-1:0]       out_bits_q;

   // Handshake qualifiers and start-time configuration check.
   assign accept      = in_valid && in_ready_q;
   assign last_accept = accept && ((cnt_q + CNT_W'(1)) == num_q);
   assign cfg_ok      = (num_chunks != '0) && (num_chunks <= CNT_W'(MAX_CHUNKS));

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      cfg_err_d   = 1'b0;
      pass_start  = 1'b0;
      out_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  pass_start = 1'b1;
                  in_ready_d = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = ST_ACCUM;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_ACCUM: begin
            // in_ready low here means the last chunk is in the popcount stage
            if (last_accept) begin
               in_ready_d = 1'b0;
            end
            if (!in_ready_q) begin
               state_d = ST_ACTIVATE;
            end
         end
         ST_ACTIVATE: begin
            out_load    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and control-output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Pass configuration, chunk counter, popcount-valid and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q      <= '0;
         thr_q      <= '0;
         cnt_q      <= '0;
         pc_vld_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else if (pass_start) begin
         num_q      <= num_chunks;
         thr_q      <= threshold;
         cnt_q      <= '0;
         pc_vld_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pc_vld_q <= accept;
         if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (sat_any) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Saturating accumulate of the registered popcounts.
   always_comb begin
      sat_any = 1'b0;
      for (int unsigned n = 0; n < N_PAR; n++) begin
         sum_w[n] = SUM_W'(acc_q[n]) + SUM_W'(pc_q[n]);
         if (sum_w[n] > SUM_W'(ACC_MAX)) begin
            acc_nxt[n] = ACC_MAX;
            sat_any    = sat_any | pc_vld_q;
         end else begin
            acc_nxt[n] = sum_w[n][ACC_W-1:0];
         end
      end
   end

   // Popcount stage and per-neuron accumulators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < N_PAR; n++) begin
            pc_q[n]  <= '0;
            acc_q[n] <= '0;
         end
      end else begin
         for (int unsigned n = 0; n < N_PAR; n++) begin
            if (accept) begin
               pc_q[n] <= popcount(in_data & in_weight[n*CHUNK_W +: CHUNK_W]);
            end
            if (pass_start) begin
               acc_q[n] <= '0;
            end else if (pc_vld_q) begin
               acc_q[n] <= acc_nxt[n];
            end
         end
      end
   end

   // Result registers, captured once per pass and held until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum_q  <= '0;
         out_bits_q <= '0;
      end else if (out_load) begin
         for (int unsigned n = 0; n < N_PAR; n++) begin
            out_sum_q[n*ACC_W +: ACC_W] <= acc_q[n];
            out_bits_q[n]               <= (acc_q[n] >= thr_q);
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_bits  = out_bits_q;
   assign busy      = busy_q;
   assign cfg_err   = cfg_err_q;
   assign overflow  = overflow_q;
   // done marks the result handshake in the cycle it happens
   assign done      = out_valid_q && out_ready;

endmodule

// File: tb/tb_dbn_layer_engine.sv
// Scoreboarded bench for dbn_layer_engine: a default build and an ACC_W=8
// build share the data path; expected results are queued per pass and
// compared by per-instance monitors whenever out_valid is high.
module tb_dbn_layer_engine;

   localparam int unsigned CHUNK_W    = 256;
   localparam int unsigned N_PAR      = 16;
   localparam int unsigned ACC_W      = 32;
   localparam int unsigned ACC8_W     = 8;
   localparam int unsigned MAX_CHUNKS = 64;
   localparam int unsigned CNT_W      = 7;
   localparam int unsigned SW         = N_PAR*ACC_W;
   localparam int unsigned S8W        = N_PAR*ACC8_W;

   typedef struct packed {
      logic [SW-1:0]    sum;
      logic [N_PAR-1:0] bits;
      logic             ovf;
   } exp_t;

   typedef struct packed {
      logic [S8W-1:0]   sum;
      logic [N_PAR-1:0] bits;
      logic             ovf;
   } exp8_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic                     start8 = 1'b0;
   logic [CNT_W-1:0]         num_chunks = '0;
   logic [ACC_W-1:0]         threshold = '0;
   logic [ACC8_W-1:0]        threshold8 = '0;
   logic                     in_valid = 1'b0;
   logic [CHUNK_W-1:0]       in_data = '0;
   logic [N_PAR*CHUNK_W-1:0] in_weight = '0;
   logic                     out_ready = 1'b1;

   logic                     in_ready, out_valid, busy, done, cfg_err, overflow;
   logic [SW-1:0]            out_sum;
   logic [N_PAR-1:0]         out_bits;
   logic                     in_ready8, out_valid8, busy8, done8, cfg_err8, overflow8;
   logic [S8W-1:0]           out_sum8;
   logic [N_PAR-1:0]         out_bits8;

   exp_t  exp_q  [$];
   exp8_t exp8_q [$];
   int    wk [N_PAR];
   int    es [N_PAR];
   int    n_vec = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   dbn_layer_engine #(
      .CHUNK_W(CHUNK_W), .N_PAR(N_PAR), .ACC_W(ACC_W),
      .MAX_CHUNKS(MAX_CHUNKS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
      .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_bits(out_bits),
      .busy(busy), .done(done), .cfg_err(cfg_err), .overflow(overflow)
   );

   dbn_layer_engine #(
      .CHUNK_W(CHUNK_W), .N_PAR(N_PAR), .ACC_W(ACC8_W),
      .MAX_CHUNKS(MAX_CHUNKS), .CNT_W(CNT_W)
   ) dut8 (
      .clk(clk), .rst(rst), .start(start8), .num_chunks(num_chunks),
      .threshold(threshold8), .in_valid(in_valid), .in_ready(in_ready8),
      .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid8),
      .out_ready(out_ready), .out_sum(out_sum8), .out_bits(out_bits8),
      .busy(busy8), .done(done8), .cfg_err(cfg_err8), .overflow(overflow8)
   );

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [CHUNK_W-1:0] ones(input int k);
      logic [CHUNK_W-1:0] v;
      v = '0;
      for (int i = 0; i < k && i < int'(CHUNK_W); i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_weights();
      for (int n = 0; n < int'(N_PAR); n++) in_weight[n*CHUNK_W +: CHUNK_W] = ones(wk[n]);
   endtask

   task automatic push_exp(input logic [N_PAR-1:0] bits, input logic ovf);
      exp_t e;
      e.sum = '0;
      for (int n = 0; n < int'(N_PAR); n++) e.sum[n*ACC_W +: ACC_W] = ACC_W'(es[n]);
      e.bits = bits;
      e.ovf  = ovf;
      exp_q.push_back(e);
   endtask

   task automatic push_exp8(input logic [N_PAR-1:0] bits, input logic ovf);
      exp8_t e;
      e.sum = '0;
      for (int n = 0; n < int'(N_PAR); n++) e.sum[n*ACC8_W +: ACC8_W] = ACC8_W'(es[n]);
      e.bits = bits;
      e.ovf  = ovf;
      exp8_q.push_back(e);
   endtask

   // Called at posedge+1; pulses start for one edge.
   task automatic do_start(input bit sel, input int num, input int thr);
      num_chunks = CNT_W'(num);
      threshold  = ACC_W'(thr);
      threshold8 = ACC8_W'(thr);
      if (sel) start8 = 1'b1;
      else     start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start8 = 1'b0;
   endtask

   // Presents the current in_data/in_weight until accepted; returns at posedge+1.
   task automatic send_chunk(input bit sel);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (sel ? in_ready8 : in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL chunk_accept: in_ready not seen within 50 cycles (sel=%0d)", sel);
      end
   endtask

   // Waits for the result handshake; returns at posedge+1.
   task automatic wait_result(input bit sel);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if ((sel ? out_valid8 : out_valid) && out_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL result_wait: no handshake within 200 cycles (sel=%0d)", sel);
      end
   endtask

   // Scoreboard monitor, default build.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL result_unexpected: out_valid=1 with nothing pending, sum=%0h", out_sum);
         end else begin
            if (out_ready) check("result_handshake", {out_sum, out_bits, overflow, done},
                                 {exp_q[0].sum, exp_q[0].bits, exp_q[0].ovf, 1'b1});
            else           check("result_hold", {out_sum, out_bits, overflow, done},
                                 {exp_q[0].sum, exp_q[0].bits, exp_q[0].ovf, 1'b0});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Scoreboard monitor, ACC_W=8 build.
   always @(negedge clk) begin
      if (!rst && out_valid8) begin
         if (exp8_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL result8_unexpected: out_valid=1 with nothing pending, sum=%0h", out_sum8);
         end else begin
            if (out_ready) check("result8_handshake", {out_sum8, out_bits8, overflow8, done8},
                                 {exp8_q[0].sum, exp8_q[0].bits, exp8_q[0].ovf, 1'b1});
            else           check("result8_hold", {out_sum8, out_bits8, overflow8, done8},
                                 {exp8_q[0].sum, exp8_q[0].bits, exp8_q[0].ovf, 1'b0});
            if (out_ready) void'(exp8_q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("reset_outputs", {in_ready, out_valid, busy, done, cfg_err, overflow, out_bits, out_sum}, '0);
      check("reset_outputs8", {in_ready8, out_valid8, busy8, done8, cfg_err8, overflow8, out_bits8, out_sum8}, '0);

      // 1) single chunk, w_0 has 16 ones -> sum_0=16, bits=0001, latency 2 edges.
      in_data = '1;
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = 0; es[n] = 0; end
      wk[0] = 16; es[0] = 16;
      set_weights();
      push_exp(16'h0001, 1'b0);
      do_start(1'b0, 1, 5);
      check("busy_after_start", busy, 1);
      check("in_ready_after_start", in_ready, 1);
      send_chunk(1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("latency_not_yet", out_valid, 0);
      @(negedge clk);
      check("latency_valid", out_valid, 1);
      @(posedge clk); #1;
      check("valid_drop_after_done", {out_valid, busy, done}, 3'b000);

      // 2) 49 all-ones chunks back to back -> 49*256 = 12544, threshold equal to sum.
      in_data = '1;
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = 256; es[n] = 12544; end
      set_weights();
      push_exp(16'hFFFF, 1'b0);
      do_start(1'b0, 49, 12544);
      for (int k = 0; k < 49; k++) send_chunk(1'b0);
      in_valid = 1'b0;
      check("in_ready_after_last", in_ready, 0);
      wait_result(1'b0);

      // 3) 4 chunks with gaps, out_ready held low 10 cycles.
      //    data k = 16(k+1) low ones, w_n = 4n low ones -> sum_n = sum_k min(16(k+1),4n).
      for (int n = 0; n < int'(N_PAR); n++) begin
         wk[n] = 4*n;
         if (n <= 4)       es[n] = 16*n;
         else if (n <= 8)  es[n] = 16 + 12*n;
         else if (n <= 12) es[n] = 48 + 8*n;
         else              es[n] = 96 + 4*n;
      end
      set_weights();
      push_exp(16'hFF80, 1'b0);
      out_ready = 1'b0;
      do_start(1'b0, 4, 100);
      for (int k = 0; k < 4; k++) begin
         in_data = ones(16*(k+1));
         send_chunk(1'b0);
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         check("t3_result_ready", seen, 1);
      end
      repeat (10) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_result(1'b0);
      check("done_single_pulse", {done, out_valid}, 2'b00);

      // 4) ACC_W=8 build: two all-ones chunks saturate at 255; next pass clears overflow.
      in_data = '1;
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = 256; es[n] = 255; end
      set_weights();
      push_exp8(16'hFFFF, 1'b1);
      do_start(1'b1, 2, 200);
      send_chunk(1'b1);
      send_chunk(1'b1);
      in_valid = 1'b0;
      wait_result(1'b1);
      check("ovf8_sticky_idle", overflow8, 1);
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = 10; es[n] = 10; end
      set_weights();
      push_exp8(16'hFFFF, 1'b0);
      do_start(1'b1, 1, 10);
      check("ovf8_cleared_on_start", overflow8, 0);
      send_chunk(1'b1);
      in_valid = 1'b0;
      wait_result(1'b1);

      // 5) illegal num_chunks -> cfg_err pulse, stays idle.
      do_start(1'b0, 0, 0);
      check("cfg_err_zero", {cfg_err, busy, in_ready}, 3'b100);
      @(posedge clk); #1;
      check("cfg_err_zero_pulse_end", cfg_err, 0);
      do_start(1'b0, MAX_CHUNKS + 1, 0);
      check("cfg_err_max_plus1", {cfg_err, busy, in_ready}, 3'b100);
      @(posedge clk); #1;
      check("cfg_err_max_pulse_end", cfg_err, 0);

      // 5b) start during ACCUM ignored: w_n = n ones, 2 chunks, threshold 0 -> sums 2n, all bits.
      in_data = '1;
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = n; es[n] = 2*n; end
      set_weights();
      push_exp(16'hFFFF, 1'b0);
      do_start(1'b0, 2, 0);
      send_chunk(1'b0);
      in_valid = 1'b0;
      do_start(1'b0, 1, 999);
      check("start_in_accum_ignored", {cfg_err, busy, in_ready}, 3'b011);
      send_chunk(1'b0);
      in_valid = 1'b0;
      wait_result(1'b0);

      // 6) reset during chunk 3 of 8 -> outputs clear immediately; fresh pass correct.
      in_data = '1;
      for (int n = 0; n < int'(N_PAR); n++) wk[n] = 256;
      set_weights();
      do_start(1'b0, 8, 1);
      for (int k = 0; k < 3; k++) send_chunk(1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_pass", {in_ready, out_valid, busy, done, cfg_err, overflow, out_bits, out_sum}, '0);
      check("rst_mid_pass8", {in_ready8, out_valid8, busy8, done8, cfg_err8, overflow8, out_bits8, out_sum8}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int n = 0; n < int'(N_PAR); n++) begin wk[n] = n; es[n] = n; end
      set_weights();
      push_exp(16'hFFF8, 1'b0);
      do_start(1'b0, 1, 3);
      send_chunk(1'b0);
      in_valid = 1'b0;
      wait_result(1'b0);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size() + exp8_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
